// File: rtl/tx_pkg.sv
// Shared types and constants for the audio transmit path: arbiter state
// encoding plus the word width and pulse timing also used by the transmitter.
package tx_pkg;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_t;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int PULSE_HI_CYCLES = 8;
    localparam int PULSE_LO_CYCLES = 4;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first set bit of full strictly after rr, wrapping modulo NUM_REQ.
// Purely combinational, no latency, no backpressure.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] full,
    input  logic [PW-1:0]      rr,
    output logic [PW-1:0]      grant,
    output logic               any_valid
);

    int idx;

    // Walk from the farthest candidate back to rr+1 so the nearest hit wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr) + k) % NUM_REQ;
            if (full[idx[PW-1:0]]) begin
                grant     = idx[PW-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin share of one serial transmitter among NUM_REQ one-word slots; issue 2 cycles after load.
// Backpressure: a slot's ready drops while it holds an unsent word and reopens in its ISSUE cycle.
module tx_arbiter
    import tx_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic                       tx_valid_out,
    output logic [WIDTH-1:0]           tx_data_out,
    input  logic                       tx_busy_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
    output logic                       timeout_err_out
);

    localparam int PW   = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(ACK_TIMEOUT) + 1;

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] drain;
    logic [NUM_REQ-1:0] load;
    logic [WIDTH-1:0]   slot_dat [NUM_REQ];
    logic [PW-1:0]      rr;
    logic [PW-1:0]      pick;
    logic [PW-1:0]      pick_grant;
    logic               pick_any;
    logic [WD_W-1:0]    wd;
    logic               wd_expire;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .full      (full),
        .rr        (rr),
        .grant     (pick_grant),
        .any_valid (pick_any)
    );

    assign drain         = (state == ISSUE) ? (NUM_REQ'(1) << pick) : '0;
    assign req_ready_out = ~full | drain;
    assign load          = req_valid_in & req_ready_out;
    assign wd_expire     = (wd == WD_W'(ACK_TIMEOUT - 1));

    // The drained word is read from the slot before the same-cycle reload lands.
    assign tx_valid_out = (state == ISSUE);
    assign tx_data_out  = (state == ISSUE) ? slot_dat[pick] : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (pick_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy_in)     state_nxt = WAIT_LO;
                else if (wd_expire) state_nxt = ARB;
            end
            WAIT_LO: if (!tx_busy_in) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= ARB;
            rr              <= PW'(NUM_REQ - 1);
            pick            <= '0;
            grant_id_out    <= '0;
            wd              <= '0;
            timeout_err_out <= 1'b0;
            full            <= '0;
        end else begin
            state <= state_nxt;
            full  <= (full & ~drain) | load;
            if (state == ARB && pick_any)
                pick <= pick_grant;
            if (state == ISSUE) begin
                rr           <= pick;
                grant_id_out <= pick;
                wd           <= '0;
            end
            // A lost acknowledge drops the word and frees the transmitter slot in time.
            if (state == WAIT_HI && !tx_busy_in) begin
                if (wd_expire)
                    timeout_err_out <= 1'b1;
                else
                    wd <= wd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i])
                slot_dat[i] <= req_data_in[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a simple busy-pulse transmitter model.
module tb_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int WIDTH       = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int LEN         = 4;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic [NUM_REQ-1:0]   req_valid_in = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data_in = '0;
    logic [NUM_REQ-1:0]   req_ready_out;
    logic                 tx_valid_out;
    logic [WIDTH-1:0]     tx_data_out;
    logic                 tx_busy_in;
    logic [1:0]           grant_id_out;
    logic                 timeout_err_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic tx_en = 1'b1;
    int   busy_cnt;
    int   viol = 0;
    int   since = 100;
    logic prev_valid = 1'b0;
    logic [WIDTH-1:0] dq[$];
    logic [1:0]       gq[$];

    tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .WIDTH       (WIDTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_valid_in    (req_valid_in),
        .req_data_in     (req_data_in),
        .req_ready_out   (req_ready_out),
        .tx_valid_out    (tx_valid_out),
        .tx_data_out     (tx_data_out),
        .tx_busy_in      (tx_busy_in),
        .grant_id_out    (grant_id_out),
        .timeout_err_out (timeout_err_out)
    );

    always #5 clk_in = ~clk_in;

    // Transmitter: busy for LEN cycles starting the cycle after an accepted pulse.
    assign tx_busy_in = (busy_cnt != 0);
    always @(posedge clk_in) begin
        if (rst_in)                       busy_cnt <= 0;
        else if (tx_valid_out && tx_en)   busy_cnt <= LEN;
        else if (busy_cnt != 0)           busy_cnt <= busy_cnt - 1;
    end

    // Log issued words and grants; flag pulses during busy or too close together.
    always @(negedge clk_in) begin
        if (prev_valid) gq.push_back(grant_id_out);
        prev_valid = tx_valid_out;
        if (tx_valid_out) begin
            dq.push_back(tx_data_out);
            if (tx_busy_in || since <= 2) viol++;
            since = 0;
        end else if (since < 100) begin
            since++;
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle;
        repeat (LEN + 8) tick();
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        repeat (3) tick();
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();
        n_cmp++; if (tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", tx_valid_out); end
        n_cmp++; if (tx_data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h exp 00", tx_data_out); end
        n_cmp++; if (grant_id_out !== 2'd0) begin n_bad++; $display("FAIL reset_grant got %0d exp 0", grant_id_out); end
        n_cmp++; if (timeout_err_out !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", timeout_err_out); end
        n_cmp++; if (req_ready_out !== 4'hF) begin n_bad++; $display("FAIL reset_ready got %h exp f", req_ready_out); end
    endtask

    task automatic test_round_robin;
        logic [WIDTH-1:0] exp_d;
        dq.delete(); gq.delete(); viol = 0;
        @(negedge clk_in);
        req_valid_in = 4'hF;
        req_data_in  = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        req_valid_in = '0;
        for (int k = 0; k < 200 && gq.size() < 4; k++) tick();
        n_cmp++; if (gq.size() !== 4) begin n_bad++; $display("FAIL rr_count got %0d exp 4", gq.size()); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'h10 + 8'(i);
            n_cmp++; if (gq[i] !== 2'(i)) begin n_bad++; $display("FAIL rr_grant%0d got %0d exp %0d", i, gq[i], i); end
            n_cmp++; if (dq[i] !== exp_d) begin n_bad++; $display("FAIL rr_data%0d got %h exp %h", i, dq[i], exp_d); end
        end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL rr_spacing got %0d violations exp 0", viol); end
        wait_idle();
    endtask

    task automatic test_single;
        @(negedge clk_in);
        req_valid_in = 4'b0100;
        req_data_in  = 32'h00A5_0000;
        tick();
        req_valid_in = '0;
        n_cmp++; if (tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL single_early got %b exp 0", tx_valid_out); end
        tick();
        n_cmp++; if (tx_valid_out !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b exp 1", tx_valid_out); end
        n_cmp++; if (tx_data_out !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h exp a5", tx_data_out); end
        n_cmp++; if (req_ready_out[2] !== 1'b1) begin n_bad++; $display("FAIL single_ready_issue got %b exp 1", req_ready_out[2]); end
        tick();
        n_cmp++; if (tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL single_pulse_len got %b exp 0", tx_valid_out); end
        n_cmp++; if (grant_id_out !== 2'd2) begin n_bad++; $display("FAIL single_grant got %0d exp 2", grant_id_out); end
        n_cmp++; if (req_ready_out[2] !== 1'b1) begin n_bad++; $display("FAIL single_ready_after got %b exp 1", req_ready_out[2]); end
        wait_idle();
    endtask

    task automatic test_fairness;
        logic [1:0]       exp_g;
        logic [WIDTH-1:0] exp_d;
        dq.delete(); gq.delete();
        @(negedge clk_in);
        req_valid_in = 4'b1001;
        req_data_in  = {8'h33, 8'h00, 8'h00, 8'h30};
        for (int k = 0; k < 200 && gq.size() < 4; k++) tick();
        req_valid_in = '0;
        repeat (40) tick();
        n_cmp++; if (gq.size() < 4) begin n_bad++; $display("FAIL fair_count got %0d exp >=4", gq.size()); end
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'd3 : 2'd0;
            exp_d = (i % 2 == 0) ? 8'h33 : 8'h30;
            n_cmp++; if (gq[i] !== exp_g) begin n_bad++; $display("FAIL fair_grant%0d got %0d exp %0d", i, gq[i], exp_g); end
            n_cmp++; if (dq[i] !== exp_d) begin n_bad++; $display("FAIL fair_data%0d got %h exp %h", i, dq[i], exp_d); end
        end
        wait_idle();
    endtask

    task automatic test_backpressure;
        viol = 0;
        @(negedge clk_in);
        req_valid_in = 4'b0001;
        req_data_in  = 32'h0000_00B0;
        tick();
        req_valid_in = '0;
        for (int k = 0; k < 50 && !tx_busy_in; k++) tick();
        n_cmp++; if (tx_busy_in !== 1'b1) begin n_bad++; $display("FAIL bp_busy got %b exp 1", tx_busy_in); end
        @(negedge clk_in);
        req_valid_in = 4'b0010;
        req_data_in  = 32'h0000_0100;
        tick();
        req_data_in  = 32'h0000_0200;
        n_cmp++; if (req_ready_out[1] !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full got %b exp 0", req_ready_out[1]); end
        for (int k = 0; k < 50 && !tx_valid_out; k++) tick();
        n_cmp++; if (tx_data_out !== 8'h01) begin n_bad++; $display("FAIL bp_first_data got %h exp 01", tx_data_out); end
        n_cmp++; if (req_ready_out[1] !== 1'b1) begin n_bad++; $display("FAIL bp_ready_issue got %b exp 1", req_ready_out[1]); end
        tick();
        req_valid_in = '0;
        n_cmp++; if (req_ready_out[1] !== 1'b0) begin n_bad++; $display("FAIL bp_reloaded got %b exp 0", req_ready_out[1]); end
        for (int k = 0; k < 50 && !tx_valid_out; k++) tick();
        n_cmp++; if (tx_data_out !== 8'h02) begin n_bad++; $display("FAIL bp_second_data got %h exp 02", tx_data_out); end
        tick();
        n_cmp++; if (grant_id_out !== 2'd1) begin n_bad++; $display("FAIL bp_grant got %0d exp 1", grant_id_out); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL bp_spacing got %0d violations exp 0", viol); end
        wait_idle();
    endtask

    task automatic test_watchdog;
        tx_en = 1'b0;
        @(negedge clk_in);
        req_valid_in = 4'b1100;
        req_data_in  = {8'hC3, 8'hC2, 8'h00, 8'h00};
        tick();
        req_valid_in = '0;
        for (int k = 0; k < 50 && !tx_valid_out; k++) tick();
        n_cmp++; if (tx_data_out !== 8'hC2) begin n_bad++; $display("FAIL wd_first_data got %h exp c2", tx_data_out); end
        tick();
        repeat (ACK_TIMEOUT - 1) tick();
        n_cmp++; if (timeout_err_out !== 1'b0) begin n_bad++; $display("FAIL wd_early got %b exp 0", timeout_err_out); end
        tick();
        n_cmp++; if (timeout_err_out !== 1'b1) begin n_bad++; $display("FAIL wd_err got %b exp 1", timeout_err_out); end
        n_cmp++; if (tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL wd_arb got %b exp 0", tx_valid_out); end
        tick();
        n_cmp++; if (tx_valid_out !== 1'b1) begin n_bad++; $display("FAIL wd_next_valid got %b exp 1", tx_valid_out); end
        n_cmp++; if (tx_data_out !== 8'hC3) begin n_bad++; $display("FAIL wd_next_data got %h exp c3", tx_data_out); end
        repeat (ACK_TIMEOUT + 8) tick();
        n_cmp++; if (timeout_err_out !== 1'b1) begin n_bad++; $display("FAIL wd_sticky got %b exp 1", timeout_err_out); end
        tx_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        @(negedge clk_in);
        req_valid_in = 4'hF;
        req_data_in  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        tick();
        req_valid_in = '0;
        for (int k = 0; k < 50 && !tx_busy_in; k++) tick();
        tick();
        n_cmp++; if (req_ready_out !== 4'b0001) begin n_bad++; $display("FAIL rm_three_full got %b exp 0001", req_ready_out); end
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        n_cmp++; if (tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %b exp 0", tx_valid_out); end
        n_cmp++; if (tx_data_out !== 8'h00) begin n_bad++; $display("FAIL rm_data got %h exp 00", tx_data_out); end
        n_cmp++; if (grant_id_out !== 2'd0) begin n_bad++; $display("FAIL rm_grant got %0d exp 0", grant_id_out); end
        n_cmp++; if (timeout_err_out !== 1'b0) begin n_bad++; $display("FAIL rm_err got %b exp 0", timeout_err_out); end
        n_cmp++; if (req_ready_out !== 4'hF) begin n_bad++; $display("FAIL rm_ready got %b exp 1111", req_ready_out); end
        @(negedge clk_in);
        rst_in = 1'b0;
        req_valid_in = 4'b1010;
        req_data_in  = {8'hE3, 8'h00, 8'hE1, 8'h00};
        tick();
        req_valid_in = '0;
        for (int k = 0; k < 50 && !tx_valid_out; k++) tick();
        n_cmp++; if (tx_data_out !== 8'hE1) begin n_bad++; $display("FAIL rm_first_data got %h exp e1", tx_data_out); end
        tick();
        n_cmp++; if (grant_id_out !== 2'd1) begin n_bad++; $display("FAIL rm_first_grant got %0d exp 1", grant_id_out); end
        wait_idle();
        wait_idle();
        @(negedge clk_in);
        req_valid_in = 4'hF;
        req_data_in  = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        rst_in = 1'b1;
        tick();
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();
        req_valid_in = '0;
        for (int k = 0; k < 50 && !tx_valid_out; k++) tick();
        n_cmp++; if (tx_data_out !== 8'hF0) begin n_bad++; $display("FAIL rm_post_data got %h exp f0", tx_data_out); end
        tick();
        n_cmp++; if (grant_id_out !== 2'd0) begin n_bad++; $display("FAIL rm_post_grant got %0d exp 0", grant_id_out); end
        repeat (60) tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
